// File: rtl/exec_pkg.sv
// Shared types for the integer/branch execute unit; is_younger() is also used by RS and ROB.
package exec_pkg;

    localparam int unsigned PREG_WIDTH = 7;
    localparam int unsigned ROB_WIDTH  = 4;
    localparam int unsigned XLEN       = 32;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_SLL  = 4'd2,
        OP_SLT  = 4'd3,
        OP_SLTU = 4'd4,
        OP_XOR  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_OR   = 4'd8,
        OP_AND  = 4'd9,
        OP_BEQ  = 4'd10,
        OP_BNE  = 4'd11,
        OP_BLT  = 4'd12,
        OP_BGE  = 4'd13,
        OP_BLTU = 4'd14,
        OP_BGEU = 4'd15
    } alu_op_e;

    localparam logic [3:0] BR_OP_BASE = 4'd10;

    typedef struct packed {
        logic [PREG_WIDTH-1:0] prs1;
        logic [PREG_WIDTH-1:0] prs2;
        logic [PREG_WIDTH-1:0] prd;
        logic [ROB_WIDTH-1:0]  rob_tag;
        logic [XLEN-1:0]       imm;
        logic [XLEN-1:0]       pc;
        alu_op_e               op;
        logic                  alusrc;
        logic                  pred_taken;
        logic [XLEN-1:0]       pred_target;
    } rr_entry_t;

    typedef struct packed {
        logic [PREG_WIDTH-1:0] prd;
        logic [XLEN-1:0]       data;
        logic [ROB_WIDTH-1:0]  rob_tag;
        logic                  mis;
        logic [XLEN-1:0]       redirect_pc;
    } ex_entry_t;

    function automatic logic is_branch(input alu_op_e op);
        return 4'(op) >= BR_OP_BASE;
    endfunction

    // Modulo age compare: tag is strictly younger than flush_tag within half the ROB ring.
    function automatic logic is_younger(input logic [ROB_WIDTH-1:0] tag,
                                        input logic [ROB_WIDTH-1:0] flush_tag);
        logic [ROB_WIDTH-1:0] d;
        d = tag - flush_tag;
        return (d != '0) && !d[ROB_WIDTH-1];
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU and branch comparator.
module alu_core
    import exec_pkg::*;
(
    input  alu_op_e         op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result,
    output logic            br_taken
);

    logic [4:0] shamt;
    logic       lt_s;
    logic       lt_u;

    assign shamt = b[4:0];
    assign lt_s  = $signed(a) < $signed(b);
    assign lt_u  = a < b;

    always_comb begin
        result   = '0;
        br_taken = 1'b0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_SLL:  result = a << shamt;
            OP_SLT:  result = {{(XLEN-1){1'b0}}, lt_s};
            OP_SLTU: result = {{(XLEN-1){1'b0}}, lt_u};
            OP_XOR:  result = a ^ b;
            OP_SRL:  result = a >> shamt;
            OP_SRA:  result = XLEN'($signed(a) >>> shamt);
            OP_OR:   result = a | b;
            OP_AND:  result = a & b;
            OP_BEQ:  br_taken = (a == b);
            OP_BNE:  br_taken = (a != b);
            OP_BLT:  br_taken = lt_s;
            OP_BGE:  br_taken = !lt_s;
            OP_BLTU: br_taken = lt_u;
            OP_BGEU: br_taken = !lt_u;
            default: begin
                result   = '0;
                br_taken = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_branch_exec.sv
// Two-stage (RR, EX) integer/branch execute unit with CDB bypass, CDB handshake,
// branch resolution and ROB-tag based flush.
module alu_branch_exec
    import exec_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_issue_valid,
    output logic                  o_ready,
    input  logic [PREG_WIDTH-1:0] i_prs1,
    input  logic [PREG_WIDTH-1:0] i_prs2,
    input  logic [PREG_WIDTH-1:0] i_prd,
    input  logic [ROB_WIDTH-1:0]  i_rob_tag,
    input  logic [XLEN-1:0]       i_imm,
    input  logic [XLEN-1:0]       i_pc,
    input  alu_op_e               i_alu_op,
    input  logic                  i_alusrc,
    input  logic                  i_pred_taken,
    input  logic [XLEN-1:0]       i_pred_target,
    output logic [PREG_WIDTH-1:0] o_prf_raddr1,
    output logic [PREG_WIDTH-1:0] o_prf_raddr2,
    input  logic [XLEN-1:0]       i_prf_rdata1,
    input  logic [XLEN-1:0]       i_prf_rdata2,
    input  logic                  i_cdb_valid,
    input  logic [PREG_WIDTH-1:0] i_cdb_prd,
    input  logic [XLEN-1:0]       i_cdb_data,
    output logic                  o_cdb_req,
    input  logic                  i_cdb_grant,
    output logic [PREG_WIDTH-1:0] o_cdb_prd,
    output logic [XLEN-1:0]       o_cdb_data,
    output logic [ROB_WIDTH-1:0]  o_cdb_rob_tag,
    output logic                  o_mispredict,
    output logic [ROB_WIDTH-1:0]  o_mispredict_rob_tag,
    output logic [XLEN-1:0]       o_redirect_pc,
    input  logic                  i_flush,
    input  logic [ROB_WIDTH-1:0]  i_flush_rob_tag
);

    logic                 rr_valid;
    rr_entry_t            rr_q;
    logic                 ex_valid;
    ex_entry_t            ex_q;
    logic                 mis_q;
    logic [ROB_WIDTH-1:0] mis_tag_q;
    logic [XLEN-1:0]      redirect_q;

    logic                 rr_adv;
    logic                 rr_move;
    logic                 rr_squash;
    logic                 ex_squash;
    logic                 ex_fire;
    logic                 issue_acc;
    logic                 rr_is_br;
    logic [XLEN-1:0]      op_a;
    logic [XLEN-1:0]      op_b;
    logic [XLEN-1:0]      alu_res;
    logic                 br_taken;
    logic [XLEN-1:0]      br_target;
    logic [XLEN-1:0]      seq_pc;
    rr_entry_t            rr_d;
    ex_entry_t            ex_d;

    // Handshake: RR may advance whenever EX is empty or being drained this cycle.
    assign rr_adv    = !ex_valid || i_cdb_grant;
    assign o_ready   = !rr_valid || rr_adv;
    assign issue_acc = i_issue_valid && o_ready && !i_flush;
    assign rr_move   = rr_valid && rr_adv;
    assign rr_squash = i_flush && rr_valid && is_younger(rr_q.rob_tag, i_flush_rob_tag);
    assign ex_squash = i_flush && ex_valid && is_younger(ex_q.rob_tag, i_flush_rob_tag);
    assign ex_fire   = ex_valid && i_cdb_grant && !ex_squash;

    assign o_prf_raddr1 = rr_q.prs1;
    assign o_prf_raddr2 = rr_q.prs2;
    assign rr_is_br     = is_branch(rr_q.op);

    // Operand select: preg 0 reads zero, CDB broadcast overrides the PRF read.
    always_comb begin
        op_a = '0;
        op_b = '0;
        if (rr_q.prs1 != '0) begin
            op_a = (i_cdb_valid && (i_cdb_prd == rr_q.prs1)) ? i_cdb_data : i_prf_rdata1;
        end
        if (rr_q.prs2 != '0) begin
            op_b = (i_cdb_valid && (i_cdb_prd == rr_q.prs2)) ? i_cdb_data : i_prf_rdata2;
        end
        if (rr_q.alusrc && !rr_is_br) begin
            op_b = rr_q.imm;
        end
    end

    alu_core u_alu_core (
        .op       (rr_q.op),
        .a        (op_a),
        .b        (op_b),
        .result   (alu_res),
        .br_taken (br_taken)
    );

    assign br_target = rr_q.pc + rr_q.imm;
    assign seq_pc    = rr_q.pc + XLEN'(4);

    always_comb begin
        ex_d             = '0;
        ex_d.rob_tag     = rr_q.rob_tag;
        ex_d.prd         = rr_is_br ? '0 : rr_q.prd;
        ex_d.data        = rr_is_br ? '0 : alu_res;
        ex_d.mis         = rr_is_br &&
                           ((br_taken != rr_q.pred_taken) ||
                            (br_taken && (rr_q.pred_target != br_target)));
        ex_d.redirect_pc = br_taken ? br_target : seq_pc;
    end

    always_comb begin
        rr_d             = '0;
        rr_d.prs1        = i_prs1;
        rr_d.prs2        = i_prs2;
        rr_d.prd         = i_prd;
        rr_d.rob_tag     = i_rob_tag;
        rr_d.imm         = i_imm;
        rr_d.pc          = i_pc;
        rr_d.op          = i_alu_op;
        rr_d.alusrc      = i_alusrc;
        rr_d.pred_taken  = i_pred_taken;
        rr_d.pred_target = i_pred_target;
    end

    // Pipeline registers; reset dominates flush, grant and issue.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_valid   <= 1'b0;
            rr_q       <= '0;
            ex_valid   <= 1'b0;
            ex_q       <= '0;
            mis_q      <= 1'b0;
            mis_tag_q  <= '0;
            redirect_q <= '0;
        end else begin
            if (issue_acc) begin
                rr_valid <= 1'b1;
                rr_q     <= rr_d;
            end else if (rr_move || rr_squash) begin
                rr_valid <= 1'b0;
            end

            if (rr_move) begin
                ex_valid <= !rr_squash;
                ex_q     <= ex_d;
            end else if (ex_valid && (i_cdb_grant || ex_squash)) begin
                ex_valid <= 1'b0;
            end

            mis_q <= ex_fire && ex_q.mis;
            if (ex_fire && ex_q.mis) begin
                mis_tag_q  <= ex_q.rob_tag;
                redirect_q <= ex_q.redirect_pc;
            end
        end
    end

    assign o_cdb_req            = ex_valid;
    assign o_cdb_prd            = ex_q.prd;
    assign o_cdb_data           = ex_q.data;
    assign o_cdb_rob_tag        = ex_q.rob_tag;
    assign o_mispredict         = mis_q;
    assign o_mispredict_rob_tag = mis_tag_q;
    assign o_redirect_pc        = redirect_q;

endmodule

// File: tb/tb_alu_branch_exec.sv
// Directed self-checking bench for alu_branch_exec.
module tb_alu_branch_exec;
    import exec_pkg::*;

    logic                  clk;
    logic                  reset;
    logic                  i_issue_valid;
    logic                  o_ready;
    logic [PREG_WIDTH-1:0] i_prs1, i_prs2, i_prd;
    logic [ROB_WIDTH-1:0]  i_rob_tag;
    logic [31:0]           i_imm, i_pc;
    alu_op_e               i_alu_op;
    logic                  i_alusrc, i_pred_taken;
    logic [31:0]           i_pred_target;
    logic [PREG_WIDTH-1:0] o_prf_raddr1, o_prf_raddr2;
    logic [31:0]           i_prf_rdata1, i_prf_rdata2;
    logic                  i_cdb_valid;
    logic [PREG_WIDTH-1:0] i_cdb_prd;
    logic [31:0]           i_cdb_data;
    logic                  o_cdb_req, i_cdb_grant;
    logic [PREG_WIDTH-1:0] o_cdb_prd;
    logic [31:0]           o_cdb_data;
    logic [ROB_WIDTH-1:0]  o_cdb_rob_tag;
    logic                  o_mispredict;
    logic [ROB_WIDTH-1:0]  o_mispredict_rob_tag;
    logic [31:0]           o_redirect_pc;
    logic                  i_flush;
    logic [ROB_WIDTH-1:0]  i_flush_rob_tag;

    logic [31:0] prf [128];
    int total;
    int bad;

    assign i_prf_rdata1 = prf[o_prf_raddr1];
    assign i_prf_rdata2 = prf[o_prf_raddr2];

    alu_branch_exec dut (
        .clk                  (clk),
        .reset                (reset),
        .i_issue_valid        (i_issue_valid),
        .o_ready              (o_ready),
        .i_prs1               (i_prs1),
        .i_prs2               (i_prs2),
        .i_prd                (i_prd),
        .i_rob_tag            (i_rob_tag),
        .i_imm                (i_imm),
        .i_pc                 (i_pc),
        .i_alu_op             (i_alu_op),
        .i_alusrc             (i_alusrc),
        .i_pred_taken         (i_pred_taken),
        .i_pred_target        (i_pred_target),
        .o_prf_raddr1         (o_prf_raddr1),
        .o_prf_raddr2         (o_prf_raddr2),
        .i_prf_rdata1         (i_prf_rdata1),
        .i_prf_rdata2         (i_prf_rdata2),
        .i_cdb_valid          (i_cdb_valid),
        .i_cdb_prd            (i_cdb_prd),
        .i_cdb_data           (i_cdb_data),
        .o_cdb_req            (o_cdb_req),
        .i_cdb_grant          (i_cdb_grant),
        .o_cdb_prd            (o_cdb_prd),
        .o_cdb_data           (o_cdb_data),
        .o_cdb_rob_tag        (o_cdb_rob_tag),
        .o_mispredict         (o_mispredict),
        .o_mispredict_rob_tag (o_mispredict_rob_tag),
        .o_redirect_pc        (o_redirect_pc),
        .i_flush              (i_flush),
        .i_flush_rob_tag      (i_flush_rob_tag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_issue(input alu_op_e op, input logic [6:0] p1, input logic [6:0] p2,
                             input logic [6:0] pd, input logic [3:0] tag, input logic [31:0] imm,
                             input logic [31:0] pc, input logic asrc, input logic pt,
                             input logic [31:0] ptgt);
        i_issue_valid = 1'b1;
        i_alu_op      = op;
        i_prs1        = p1;
        i_prs2        = p2;
        i_prd         = pd;
        i_rob_tag     = tag;
        i_imm         = imm;
        i_pc          = pc;
        i_alusrc      = asrc;
        i_pred_taken  = pt;
        i_pred_target = ptgt;
    endtask

    // Issue one ALU uop with grant held high; result must appear two cycles after issue.
    task automatic run_alu(input string name, input alu_op_e op, input logic [6:0] p1,
                           input logic [6:0] p2, input logic asrc, input logic [31:0] imm,
                           input logic [3:0] tag, input logic [31:0] exp);
        set_issue(op, p1, p2, 7'd10, tag, imm, 32'h0, asrc, 1'b0, 32'h0);
        tick;
        i_issue_valid = 1'b0;
        chk({name, "_req_n1"}, 32'(o_cdb_req), 32'd0);
        tick;
        chk({name, "_req_n2"}, 32'(o_cdb_req), 32'd1);
        chk({name, "_data"}, o_cdb_data, exp);
        chk({name, "_tag"}, 32'(o_cdb_rob_tag), 32'(tag));
    endtask

    // Issue one branch with grant held high; check CDB write and the mispredict pulse.
    task automatic run_br(input string name, input alu_op_e op, input logic [6:0] p1,
                          input logic [6:0] p2, input logic [3:0] tag, input logic [31:0] imm,
                          input logic [31:0] pc, input logic pt, input logic [31:0] ptgt,
                          input logic exp_mis, input logic [31:0] exp_redirect);
        set_issue(op, p1, p2, 7'd33, tag, imm, pc, 1'b0, pt, ptgt);
        tick;
        i_issue_valid = 1'b0;
        tick;
        chk({name, "_req"}, 32'(o_cdb_req), 32'd1);
        chk({name, "_prd0"}, 32'(o_cdb_prd), 32'd0);
        chk({name, "_data0"}, o_cdb_data, 32'd0);
        chk({name, "_mis_early"}, 32'(o_mispredict), 32'd0);
        tick;
        chk({name, "_mis"}, 32'(o_mispredict), 32'(exp_mis));
        if (exp_mis) begin
            chk({name, "_mis_tag"}, 32'(o_mispredict_rob_tag), 32'(tag));
            chk({name, "_redirect"}, o_redirect_pc, exp_redirect);
        end
        tick;
        chk({name, "_mis_off"}, 32'(o_mispredict), 32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clk   = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 128; i++) prf[i] = 32'hDEAD0000 + 32'(i);
        prf[0]  = 32'hBAD0BAD0;
        prf[5]  = 32'd7;
        prf[9]  = 32'h11;
        prf[12] = 32'h80000000;
        set_issue(OP_ADD, 7'd0, 7'd0, 7'd0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        i_issue_valid   = 1'b0;
        i_cdb_valid     = 1'b0;
        i_cdb_prd       = '0;
        i_cdb_data      = '0;
        i_cdb_grant     = 1'b1;
        i_flush         = 1'b0;
        i_flush_rob_tag = '0;
        tick;
        tick;
        reset = 1'b0;
        #1;
        chk("rst_req", 32'(o_cdb_req), 32'd0);
        chk("rst_mis", 32'(o_mispredict), 32'd0);
        chk("rst_data", o_cdb_data, 32'd0);
        chk("rst_redirect", o_redirect_pc, 32'd0);
        chk("rst_ready", 32'(o_ready), 32'd1);

        // Basic ALU ops with grant held high
        run_alu("add_imm", OP_ADD, 7'd5, 7'd0, 1'b1, 32'd3, 4'd3, 32'd10);
        chk("add_prd", 32'(o_cdb_prd), 32'd10);
        run_alu("sub_wrap", OP_SUB, 7'd5, 7'd9, 1'b0, 32'd0, 4'd4, 32'hFFFFFFF6);
        run_alu("sra", OP_SRA, 7'd12, 7'd0, 1'b1, 32'd4, 4'd5, 32'hF8000000);
        run_alu("srl", OP_SRL, 7'd12, 7'd0, 1'b1, 32'd4, 4'd6, 32'h08000000);
        run_alu("slt", OP_SLT, 7'd12, 7'd0, 1'b1, 32'd1, 4'd7, 32'd1);
        run_alu("sltu", OP_SLTU, 7'd12, 7'd0, 1'b1, 32'd1, 4'd8, 32'd0);
        run_alu("p0_zero", OP_ADD, 7'd0, 7'd0, 1'b1, 32'd5, 4'd9, 32'd5);
        run_alu("sll_5bit", OP_SLL, 7'd5, 7'd0, 1'b1, 32'h21, 4'd10, 32'd14);
        run_alu("xor", OP_XOR, 7'd5, 7'd9, 1'b0, 32'd0, 4'd11, 32'h16);

        // CDB bypass during RR
        set_issue(OP_ADD, 7'd9, 7'd0, 7'd21, 4'd4, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        tick;
        i_issue_valid = 1'b0;
        i_cdb_valid   = 1'b1;
        i_cdb_prd     = 7'd9;
        i_cdb_data    = 32'h55;
        #1;
        chk("byp_raddr", 32'(o_prf_raddr1), 32'd9);
        tick;
        i_cdb_valid = 1'b0;
        chk("byp_req", 32'(o_cdb_req), 32'd1);
        chk("byp_data", o_cdb_data, 32'h55);
        chk("byp_prd", 32'(o_cdb_prd), 32'd21);

        // Branch resolution
        run_br("beq_mis", OP_BEQ, 7'd5, 7'd5, 4'd7, 32'h20, 32'h100, 1'b0, 32'h0, 1'b1, 32'h120);
        run_br("bne_ok", OP_BNE, 7'd5, 7'd5, 4'd8, 32'h20, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
        run_br("blt_ok", OP_BLT, 7'd12, 7'd5, 4'd9, 32'h40, 32'h200, 1'b1, 32'h240, 1'b0, 32'h0);
        run_br("bgeu_tgt", OP_BGEU, 7'd12, 7'd5, 4'd10, 32'h10, 32'h300, 1'b1, 32'h999, 1'b1, 32'h310);

        // Backpressure: three issues with grant low, then drain
        i_cdb_grant = 1'b0;
        set_issue(OP_ADD, 7'd0, 7'd0, 7'd30, 4'd1, 32'd1, 32'd0, 1'b1, 1'b0, 32'd0);
        #1;
        chk("st_ready0", 32'(o_ready), 32'd1);
        tick;
        set_issue(OP_ADD, 7'd0, 7'd0, 7'd31, 4'd2, 32'd2, 32'd0, 1'b1, 1'b0, 32'd0);
        #1;
        chk("st_ready1", 32'(o_ready), 32'd1);
        tick;
        set_issue(OP_ADD, 7'd0, 7'd0, 7'd32, 4'd3, 32'd3, 32'd0, 1'b1, 1'b0, 32'd0);
        #1;
        chk("st_ready2", 32'(o_ready), 32'd0);
        chk("st_req2", 32'(o_cdb_req), 32'd1);
        chk("st_data2", o_cdb_data, 32'd1);
        tick;
        chk("st_ready3", 32'(o_ready), 32'd0);
        chk("st_data3", o_cdb_data, 32'd1);
        chk("st_tag3", 32'(o_cdb_rob_tag), 32'd1);
        tick;
        chk("st_data4", o_cdb_data, 32'd1);
        i_cdb_grant = 1'b1;
        #1;
        chk("st_ready4", 32'(o_ready), 32'd1);
        tick;
        i_issue_valid = 1'b0;
        chk("dr_data_b", o_cdb_data, 32'd2);
        chk("dr_tag_b", 32'(o_cdb_rob_tag), 32'd2);
        tick;
        chk("dr_data_c", o_cdb_data, 32'd3);
        chk("dr_tag_c", 32'(o_cdb_rob_tag), 32'd3);
        tick;
        chk("dr_empty", 32'(o_cdb_req), 32'd0);

        // Flush tag 6: RR tag 7 squashed, EX tag 5 completes, issue during flush ignored
        i_cdb_grant = 1'b0;
        set_issue(OP_ADD, 7'd0, 7'd0, 7'd40, 4'd5, 32'h50, 32'd0, 1'b1, 1'b0, 32'd0);
        tick;
        set_issue(OP_ADD, 7'd0, 7'd0, 7'd41, 4'd7, 32'h70, 32'd0, 1'b1, 1'b0, 32'd0);
        tick;
        i_issue_valid   = 1'b0;
        i_flush         = 1'b1;
        i_flush_rob_tag = 4'd6;
        #1;
        chk("fl_req", 32'(o_cdb_req), 32'd1);
        chk("fl_tag", 32'(o_cdb_rob_tag), 32'd5);
        tick;
        set_issue(OP_ADD, 7'd0, 7'd0, 7'd42, 4'd6, 32'h60, 32'd0, 1'b1, 1'b0, 32'd0);
        i_cdb_grant = 1'b1;
        #1;
        chk("fl_ex_kept", 32'(o_cdb_req), 32'd1);
        chk("fl_ex_data", o_cdb_data, 32'h50);
        chk("fl_rr_gone", 32'(o_ready), 32'd1);
        tick;
        i_flush       = 1'b0;
        i_issue_valid = 1'b0;
        chk("fl_after1", 32'(o_cdb_req), 32'd0);
        tick;
        chk("fl_after2", 32'(o_cdb_req), 32'd0);

        // Wrap flush: tag 15 squashes EX tag 0, grant ignored, no mispredict
        i_cdb_grant = 1'b0;
        set_issue(OP_BEQ, 7'd5, 7'd5, 7'd0, 4'd0, 32'h20, 32'h100, 1'b0, 1'b0, 32'd0);
        tick;
        i_issue_valid = 1'b0;
        tick;
        chk("wr_req", 32'(o_cdb_req), 32'd1);
        chk("wr_tag", 32'(o_cdb_rob_tag), 32'd0);
        i_flush         = 1'b1;
        i_flush_rob_tag = 4'd15;
        i_cdb_grant     = 1'b1;
        tick;
        i_flush = 1'b0;
        chk("wr_squash", 32'(o_cdb_req), 32'd0);
        chk("wr_nomis1", 32'(o_mispredict), 32'd0);
        tick;
        chk("wr_nomis2", 32'(o_mispredict), 32'd0);

        // Reset while EX requests a mispredicting branch
        i_cdb_grant = 1'b0;
        set_issue(OP_BEQ, 7'd5, 7'd5, 7'd0, 4'd2, 32'h20, 32'h100, 1'b0, 1'b0, 32'd0);
        tick;
        i_issue_valid = 1'b0;
        tick;
        chk("rs_req_before", 32'(o_cdb_req), 32'd1);
        reset       = 1'b1;
        i_cdb_grant = 1'b1;
        tick;
        reset       = 1'b0;
        i_cdb_grant = 1'b0;
        #1;
        chk("rs_req", 32'(o_cdb_req), 32'd0);
        chk("rs_ready", 32'(o_ready), 32'd1);
        chk("rs_nomis1", 32'(o_mispredict), 32'd0);
        tick;
        chk("rs_nomis2", 32'(o_mispredict), 32'd0);
        chk("rs_idle", 32'(o_cdb_req), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
